prioritized_arbiter: RTL and testbench

//  Shares one output channel between number_of_inputs valid/ready requesters using a static priority list.

---
 rtl/prioritized_arbiter_pkg.sv | 32 +++
 rtl/prioritized_arbiter_prioritizer.sv | 20 ++
 rtl/prioritized_arbiter.sv | 153 +++++++++++++++
 tb/tb_prioritized_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prioritized_arbiter_pkg.sv
// Shared types and helpers for the static-priority valid/ready arbiter.
package prioritized_arbiter_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_INPUTS = 4;
    localparam int unsigned MAX_WAIT   = 15;
    // Upper bound on requester count handled by first_set.
    localparam int unsigned MAX_RANKS  = 32;

    typedef logic [$clog2(NUM_INPUTS)-1:0] idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Lowest set position of a rank-ordered vector (rank 0 = bit 0); 0 when none set.
    function automatic int unsigned first_set(input logic [MAX_RANKS-1:0] v);
        int unsigned r;
        r = 0;
        for (int i = int'(MAX_RANKS) - 1; i >= 0; i--) begin
            if (v[i]) r = unsigned'(i);
        end
        return r;
    endfunction

    // Width of a starvation counter able to hold max_wait.
    function automatic int unsigned wait_width(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/prioritized_arbiter_prioritizer.sv
// Reorders a per-input vector into rank order: ranked_c[r] = in_vec[priority_list[r]].
module prioritized_arbiter_prioritizer
    import prioritized_arbiter_pkg::*;
#(
    parameter int unsigned data_width       = 1,
    parameter int unsigned number_of_inputs = NUM_INPUTS,
    parameter logic [number_of_inputs-1:0][$clog2(number_of_inputs)-1:0] priority_list = {2'd3, 2'd1, 2'd2, 2'd0}
) (
    input  logic [number_of_inputs-1:0][data_width-1:0] in_vec,
    output logic [number_of_inputs-1:0][data_width-1:0] ranked_c
);

    // Pure wiring permutation into rank order.
    always_comb begin
        for (int r = 0; r < int'(number_of_inputs); r++) begin
            ranked_c[r] = in_vec[priority_list[r]];
        end
    end

endmodule

// File: rtl/prioritized_arbiter.sv
// Static-priority arbiter feeding one registered valid/ready output stage.
// Optional starvation guard: define STARVE_GUARD_EN to enable per-input wait counters.
module prioritized_arbiter
    import prioritized_arbiter_pkg::*;
#(
    parameter int unsigned data_width       = DATA_W,
    parameter int unsigned number_of_inputs = NUM_INPUTS,
    parameter logic [number_of_inputs-1:0][$clog2(number_of_inputs)-1:0] priority_list = {2'd3, 2'd1, 2'd2, 2'd0},
    parameter int unsigned max_wait         = MAX_WAIT
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [number_of_inputs-1:0]                 in_valid,
    input  logic [number_of_inputs-1:0][data_width-1:0] in_data,
    output logic [number_of_inputs-1:0]                 in_ready,
    output logic                                        out_valid,
    output logic [data_width-1:0]                       out_data,
    output logic [$clog2(number_of_inputs)-1:0]         out_grant,
    input  logic                                        out_ready
);

    localparam int unsigned IW = $clog2(number_of_inputs);

    // True when priority_list is a permutation of 0..number_of_inputs-1.
    function automatic logic list_ok(input logic [number_of_inputs-1:0][IW-1:0] pl);
        logic [number_of_inputs-1:0] seen;
        logic ok;
        seen = '0;
        ok   = 1'b1;
        for (int r = 0; r < int'(number_of_inputs); r++) begin
            if (32'(pl[r]) >= number_of_inputs) ok = 1'b0;
            else if (seen[pl[r]])               ok = 1'b0;
            else                                seen[pl[r]] = 1'b1;
        end
        return ok;
    endfunction

    // Elaboration-time parameter sanity.
    if (number_of_inputs < 2 || number_of_inputs > MAX_RANKS) begin : g_bad_inputs
        $error("prioritized_arbiter: number_of_inputs out of range");
    end
    if (max_wait < 1) begin : g_bad_wait
        $error("prioritized_arbiter: max_wait must be >= 1");
    end
    if (!list_ok(priority_list)) begin : g_bad_list
        $error("prioritized_arbiter: priority_list is not a permutation");
    end

    state_t                             state_q, state_d;
    logic [number_of_inputs-1:0][0:0]   valid_vec, valid_rank;
    logic [IW-1:0]                      win_rank;
    logic [IW-1:0]                      winner;
    logic                               any_req;
    logic                               can_load;
    logic                               load;

    assign valid_vec = in_valid;

    prioritized_arbiter_prioritizer #(
        .data_width       (1),
        .number_of_inputs (number_of_inputs),
        .priority_list    (priority_list)
    ) u_valid_rank (
        .in_vec   (valid_vec),
        .ranked_c (valid_rank)
    );

`ifdef STARVE_GUARD_EN
    localparam int unsigned WW = wait_width(max_wait);

    logic [number_of_inputs-1:0][WW-1:0] wait_cnt;
    logic [number_of_inputs-1:0][0:0]    starved_vec, starved_rank;

    // An input is starved once its counter has saturated while still requesting.
    always_comb begin
        for (int i = 0; i < int'(number_of_inputs); i++) begin
            starved_vec[i] = in_valid[i] && (wait_cnt[i] == WW'(max_wait));
        end
    end

    prioritized_arbiter_prioritizer #(
        .data_width       (1),
        .number_of_inputs (number_of_inputs),
        .priority_list    (priority_list)
    ) u_starved_rank (
        .in_vec   (starved_vec),
        .ranked_c (starved_rank)
    );

    // Starved inputs pre-empt the static order; lowest rank wins among them.
    always_comb begin
        if (|starved_rank) win_rank = IW'(first_set(32'(starved_rank)));
        else               win_rank = IW'(first_set(32'(valid_rank)));
    end

    // Wait counters: count while refused, clear on grant or withdrawal, saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(number_of_inputs); i++) begin
                if (!in_valid[i] || in_ready[i])         wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WW'(max_wait))   wait_cnt[i] <= wait_cnt[i] + WW'(1);
            end
        end
    end
`else
    // Pure static priority: lowest requesting rank wins.
    always_comb begin
        win_rank = IW'(first_set(32'(valid_rank)));
    end
`endif

    assign winner   = priority_list[win_rank];
    assign any_req  = |in_valid;
    assign can_load = (state_q == EMPTY) || out_ready;
    assign load     = can_load && any_req;

    // One-hot accept strobe to the current winner whenever the stage can take a beat.
    always_comb begin
        in_ready = '0;
        if (load) in_ready[winner] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Next state: fill on any request, drain when consumed with nothing to reload.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (any_req)   state_d = FULL;
            FULL:  if (out_ready) state_d = any_req ? FULL : EMPTY;
        endcase
    end

    // Output payload register; holds its last value when nothing is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_grant <= '0;
        end else if (load) begin
            out_data  <= in_data[winner];
            out_grant <= winner;
        end
    end

    assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_prioritized_arbiter.sv
// Directed bench for prioritized_arbiter; also exercises STARVE_GUARD_EN when defined.
module tb_prioritized_arbiter;
    import prioritized_arbiter_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      in_valid;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    idx_t            out_grant;
    logic            out_ready;

    int unsigned     errors = 0;
    int unsigned     checks = 0;

    logic [9:0]      sb_q[$];
    logic            prev_hold = 1'b0;
    logic [7:0]      prev_data;
    idx_t            prev_grant;

    prioritized_arbiter #(
        .data_width       (8),
        .number_of_inputs (4),
        .max_wait         (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: one-hot ready, hold stability, and beat scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_hold = 1'b0;
        end else begin
            check("onehot0", 32'($onehot0(in_ready)), 1);
            if (prev_hold) begin
                check("hold_data", out_data, prev_data);
                check("hold_grant", out_grant, prev_grant);
                check("hold_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_extra", 0, 1);
                else begin
                    check("sb_beat", {out_grant, out_data}, sb_q[0]);
                    void'(sb_q.pop_front());
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && in_ready[i]) sb_q.push_back({2'(i), in_data[i]});
            end
            prev_hold  = out_valid && !out_ready;
            prev_data  = out_data;
            prev_grant = out_grant;
        end
    end

    initial begin
        logic [3:0] exp_rdy;
        logic [7:0] exp_dat;

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_grant", out_grant, 0);
        check("rst_ready", in_ready, 4'b0000);
        tick();
        tick();
        rst = 1'b0;

        // Static priority order 0,2,1,3.
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1 check("sp_rdy0", in_ready, 4'b0001);
        tick();
        check("sp_dat0", out_data, 8'h10);
        check("sp_gnt0", out_grant, 0);
        check("sp_val0", out_valid, 1);
        in_valid = 4'b1110;
        #1 check("sp_rdy1", in_ready, 4'b0100);
        tick();
        check("sp_dat1", out_data, 8'h12);
        check("sp_gnt1", out_grant, 2);
        in_valid = 4'b1010;
        #1 check("sp_rdy2", in_ready, 4'b0010);
        tick();
        check("sp_dat2", out_data, 8'h11);
        check("sp_gnt2", out_grant, 1);
        in_valid = 4'b1000;
        #1 check("sp_rdy3", in_ready, 4'b1000);
        tick();
        check("sp_dat3", out_data, 8'h13);
        check("sp_gnt3", out_grant, 3);
        in_valid = 4'b0000;
        #1 check("sp_rdy_idle", in_ready, 4'b0000);
        tick();
        check("sp_drain_val", out_valid, 0);
        check("sp_keep_dat", out_data, 8'h13);
        check("sp_keep_gnt", out_grant, 3);

        // Backpressure: hold for 5 cycles, then reload without a bubble.
        out_ready  = 1'b0;
        in_data[1] = 8'h21;
        in_valid   = 4'b0010;
        #1 check("bp_rdy_load", in_ready, 4'b0010);
        tick();
        check("bp_dat", out_data, 8'h21);
        check("bp_gnt", out_grant, 1);
        in_data[2] = 8'h32;
        in_valid   = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rdy_stall", in_ready, 4'b0000);
            check("bp_val_stall", out_valid, 1);
            check("bp_dat_stall", out_data, 8'h21);
            tick();
        end
        out_ready = 1'b1;
        #1 check("bp_rdy_resume", in_ready, 4'b0100);
        tick();
        check("bp_val_next", out_valid, 1);
        check("bp_dat_next", out_data, 8'h32);
        check("bp_gnt_next", out_grant, 2);
        in_valid = 4'b0000;
        tick();
        check("bp_empty", out_valid, 0);

        // Single beat on input 3: one-cycle output pulse.
        in_data[3] = 8'h4C;
        in_valid   = 4'b1000;
        #1 check("one_rdy", in_ready, 4'b1000);
        tick();
        in_valid = 4'b0000;
        #1;
        check("one_val", out_valid, 1);
        check("one_dat", out_data, 8'h4C);
        check("one_gnt", out_grant, 3);
        check("one_rdy_off", in_ready, 4'b0000);
        tick();
        check("one_val_off", out_valid, 0);
        check("one_rdy_idle", in_ready, 4'b0000);
        tick();
        check("one_val_idle", out_valid, 0);

        // Inputs 0 and 3 always requesting.
        in_data[0] = 8'h50;
        in_data[3] = 8'h53;
        in_valid   = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
`ifdef STARVE_GUARD_EN
            exp_rdy = (k % 4 == 0) ? 4'b1000 : 4'b0001;
`else
            exp_rdy = 4'b0001;
`endif
            exp_dat = (exp_rdy == 4'b1000) ? 8'h53 : 8'h50;
            #1 check("sv_rdy", in_ready, exp_rdy);
            tick();
            check("sv_dat", out_data, exp_dat);
        end
        in_valid = 4'b0000;
        tick();
        check("sv_drain", out_valid, 0);

        // Asynchronous reset while FULL.
        out_ready  = 1'b0;
        in_data[2] = 8'hAA;
        in_valid   = 4'b0100;
        tick();
        in_valid = 4'b0000;
        #1;
        check("ar_pre_dat", out_data, 8'hAA);
        check("ar_pre_val", out_valid, 1);
        rst = 1'b1;
        #1;
        check("ar_val", out_valid, 0);
        check("ar_dat", out_data, 8'h00);
        check("ar_gnt", out_grant, 0);
        check("ar_rdy", in_ready, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
